// File: rtl/frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// frame_sequencer_if : vblank/control inputs and unit start/done handshake
// Rev 1.0
// ============================================================================
interface frame_sequencer_if;
  logic       i_vblank;
  logic       i_pause;
  logic [1:0] i_speed;
  logic [3:0] i_done;
  logic [3:0] o_start;
  logic       o_busy;
  logic       o_frame;
  logic       o_overrun;
  logic       o_timeout;
  logic [7:0] o_seq_cnt;

  modport master (
    input  i_vblank, i_pause, i_speed, i_done,
    output o_start, o_busy, o_frame, o_overrun, o_timeout, o_seq_cnt
  );

  modport slave (
    output i_vblank, i_pause, i_speed, i_done,
    input  o_start, o_busy, o_frame, o_overrun, o_timeout, o_seq_cnt
  );
endinterface
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// frame_sequencer : kicks paddle, ball, collision, score units once per due vblank
// Rev 1.0
// ============================================================================
module frame_sequencer #(
  parameter int TIMEOUT = 800,
  parameter int TW      = 10
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  frame_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  logic          r_vb_s1, r_vb_s2, r_vb_s3;
  logic          r_tick;
  logic          r_frame;
  state_t        r_state, w_state_nxt;
  logic [1:0]    r_step,  w_step_nxt;
  logic [1:0]    r_div,   w_div_nxt;
  logic [TW-1:0] r_cnt,   w_cnt_nxt;
  logic          r_overrun, w_overrun_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [7:0]    r_seq_cnt, w_seq_cnt_nxt;
  logic          w_done_k;
  logic          w_cnt_end;

  assign w_done_k  = bus.i_done[r_step];
  assign w_cnt_end = (r_cnt == TW'(TIMEOUT - 1));

  // Sync flops preset high so a vblank already asserted at reset release is not a tick
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vb_s1   <= 1'b1;
      r_vb_s2   <= 1'b1;
      r_vb_s3   <= 1'b1;
      r_tick    <= 1'b0;
      r_frame   <= 1'b0;
      r_state   <= S_IDLE;
      r_step    <= 2'd0;
      r_div     <= 2'd0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_seq_cnt <= 8'd0;
    end else begin
      r_vb_s1   <= bus.i_vblank;
      r_vb_s2   <= r_vb_s1;
      r_vb_s3   <= r_vb_s2;
      r_tick    <= r_vb_s2 & ~r_vb_s3;
      r_frame   <= r_tick;
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_div     <= w_div_nxt;
      r_cnt     <= w_cnt_nxt;
      r_overrun <= w_overrun_nxt;
      r_timeout <= w_timeout_nxt;
      r_seq_cnt <= w_seq_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_div_nxt     = r_div;
    w_cnt_nxt     = r_cnt;
    w_overrun_nxt = r_overrun;
    w_timeout_nxt = r_timeout;
    w_seq_cnt_nxt = r_seq_cnt;

    if (bus.i_pause) begin
      w_div_nxt = 2'd0;
    end

    case (r_state)
      S_IDLE: begin
        if (r_tick && !bus.i_pause) begin
          if (r_div == bus.i_speed) begin
            w_div_nxt   = 2'd0;
            w_step_nxt  = 2'd0;
            w_state_nxt = S_ISSUE;
          end else begin
            w_div_nxt = r_div + 2'd1;
          end
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // A done in the final counted cycle wins over the timeout
        if (w_done_k || w_cnt_end) begin
          if (!w_done_k) begin
            w_timeout_nxt = 1'b1;
          end
          if (r_step == 2'd3) begin
            w_state_nxt = S_DONE;
          end else begin
            w_step_nxt  = r_step + 2'd1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        w_seq_cnt_nxt = r_seq_cnt + 8'd1;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (r_tick && (r_state != S_IDLE)) begin
      w_overrun_nxt = 1'b1;
    end
  end

  assign bus.o_start   = (r_state == S_ISSUE) ? (4'b0001 << r_step) : 4'b0000;
  assign bus.o_busy    = (r_state != S_IDLE);
  assign bus.o_frame   = r_frame;
  assign bus.o_overrun = r_overrun;
  assign bus.o_timeout = r_timeout;
  assign bus.o_seq_cnt = r_seq_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// tb_frame_sequencer : directed scoreboard bench for frame_sequencer
// Rev 1.0
// ============================================================================
module tb_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  frame_sequencer_if bus ();

  frame_sequencer #(.TIMEOUT(800), .TW(10)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int         total = 0;
  int         bad   = 0;
  int         cycle = 0;
  logic [3:0] exp_q[$];
  int         m_div, m_seq, m_frames, frames;
  int         resp_dly[4];
  int         pend[4];
  int         start_cyc[4];
  int         busy_run, busy_len, rise_cyc, frame_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.o_start, bus.o_busy, bus.o_frame, bus.o_overrun, bus.o_timeout, bus.o_seq_cnt};
  endfunction

  // One clock: sample outputs at the falling edge, score starts, then drive unit responses
  task automatic cyc();
    logic [3:0] nd;
    logic [3:0] e;
    @(negedge clk);
    cycle++;
    if (bus.o_frame) begin
      frames++;
      frame_cyc = cycle;
    end
    if (bus.o_busy) busy_run++;
    else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
    if (bus.o_start != 4'd0) begin
      if (exp_q.size() == 0) chk("start_unexpected", 32'(bus.o_start), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("start_order", 32'(bus.o_start), 32'(e));
      end
      for (int k = 0; k < 4; k++) if (bus.o_start[k]) start_cyc[k] = cycle;
    end
    nd = 4'd0;
    for (int k = 0; k < 4; k++) begin
      if (pend[k] > 0) begin
        pend[k]--;
        if (pend[k] == 0) nd[k] = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (bus.o_start[k] && resp_dly[k] > 0) pend[k] = resp_dly[k];
    end
    bus.i_done = nd;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_div    = 0;
    m_seq    = 0;
    m_frames = 0;
    frames   = 0;
    busy_run = 0;
    busy_len = 0;
    for (int k = 0; k < 4; k++) begin
      pend[k]      = 0;
      resp_dly[k]  = 1;
      start_cyc[k] = -1;
    end
  endtask

  task automatic do_reset();
    bus.i_vblank = 1'b1;
    bus.i_pause  = 1'b0;
    bus.i_speed  = 2'd0;
    bus.i_done   = 4'd0;
    rst = 1'b1;
    model_clear();
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  // Expected effect of one vblank rise; busy_exp marks a tick landing mid-sequence
  task automatic model_tick(input bit busy_exp);
    m_frames++;
    if (busy_exp) return;
    if (bus.i_pause) m_div = 0;
    else if (m_div == int'(bus.i_speed)) begin
      m_div = 0;
      m_seq++;
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
    end else m_div++;
  endtask

  task automatic vb_rise(input bit busy_exp);
    bus.i_vblank = 1'b0;
    repeat (4) cyc();
    bus.i_vblank = 1'b1;
    rise_cyc = cycle;
    model_tick(busy_exp);
  endtask

  task automatic settle(input int limit);
    int n = 0;
    repeat (6) cyc();
    while (bus.o_busy && n < limit) begin
      cyc();
      n++;
    end
    chk("busy_bound", 32'(bus.o_busy), 32'd0);
    repeat (2) cyc();
  endtask

  task automatic wait_start(input int k, input int limit);
    int n = 0;
    while (start_cyc[k] < 0 && n < limit) begin
      cyc();
      n++;
    end
    chk("start_seen", 32'(start_cyc[k] >= 0), 32'd1);
  endtask

  initial begin
    int f0;

    // Basic sequence, speed 0, units answer after one cycle
    do_reset();
    chk("reset_outs", 32'(outs()), 32'd0);
    repeat (6) cyc();
    chk("no_tick_at_release", 32'(frames), 32'd0);
    vb_rise(0);
    settle(100);
    chk("frame_latency", 32'(frame_cyc - rise_cyc), 32'd4);
    chk("start0_latency", 32'(start_cyc[0] - rise_cyc), 32'd4);
    chk("gap_0_1", 32'(start_cyc[1] - start_cyc[0]), 32'd2);
    chk("gap_1_2", 32'(start_cyc[2] - start_cyc[1]), 32'd2);
    chk("gap_2_3", 32'(start_cyc[3] - start_cyc[2]), 32'd2);
    chk("busy_len", 32'(busy_len), 32'd9);
    chk("frames_basic", 32'(frames), 32'd1);
    chk("seq_basic", 32'(bus.o_seq_cnt), 32'(m_seq));
    chk("flags_basic", 32'({bus.o_overrun, bus.o_timeout}), 32'd0);
    chk("sb_empty_basic", 32'(exp_q.size()), 32'd0);

    // Divider: condition div_cnt to 2 with speed 3, then six rises at speed 2
    do_reset();
    bus.i_speed = 2'd3;
    repeat (2) begin vb_rise(0); settle(100); end
    bus.i_speed = 2'd2;
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      vb_rise(0);
      settle(100);
      if (i == 0) chk("speed_tick1_runs", 32'(bus.o_seq_cnt), 32'd1);
    end
    chk("speed_frames", 32'(frames - f0), 32'd6);
    chk("speed_seq", 32'(bus.o_seq_cnt), 32'd2);
    chk("sb_empty_speed", 32'(exp_q.size()), 32'd0);

    // Ball answers in the last counted cycle: done wins, no timeout
    do_reset();
    resp_dly[1] = 800;
    vb_rise(0);
    settle(4000);
    chk("edge_gap", 32'(start_cyc[2] - start_cyc[1]), 32'd801);
    chk("edge_timeout", 32'(bus.o_timeout), 32'd0);
    chk("edge_seq", 32'(bus.o_seq_cnt), 32'd1);

    // Ball never answers
    do_reset();
    resp_dly[1] = 0;
    vb_rise(0);
    settle(4000);
    chk("to_gap", 32'(start_cyc[2] - start_cyc[1]), 32'd801);
    chk("to_timeout", 32'(bus.o_timeout), 32'd1);
    chk("to_seq", 32'(bus.o_seq_cnt), 32'd1);
    chk("to_overrun", 32'(bus.o_overrun), 32'd0);

    // Overrun: collision stalls while another vblank rises
    do_reset();
    bus.i_speed = 2'd1;
    vb_rise(0);
    settle(100);
    resp_dly[2] = 5000;
    vb_rise(0);
    wait_start(2, 200);
    vb_rise(1);
    repeat (6) cyc();
    chk("ovr_flag", 32'(bus.o_overrun), 32'd1);
    chk("ovr_busy", 32'(bus.o_busy), 32'd1);
    settle(2000);
    chk("ovr_seq", 32'(bus.o_seq_cnt), 32'd1);
    chk("ovr_timeout", 32'(bus.o_timeout), 32'd1);
    resp_dly[2] = 1;
    vb_rise(0);
    settle(100);
    chk("ovr_div_held", 32'(bus.o_seq_cnt), 32'd1);
    vb_rise(0);
    settle(100);
    chk("ovr_seq2", 32'(bus.o_seq_cnt), 32'(m_seq));
    chk("ovr_frames", 32'(frames), 32'(m_frames));
    chk("sb_empty_ovr", 32'(exp_q.size()), 32'd0);

    // Pause across three rises, then release
    do_reset();
    bus.i_pause = 1'b1;
    m_div = 0;
    repeat (3) begin vb_rise(0); settle(50); end
    chk("pause_frames", 32'(frames), 32'd3);
    chk("pause_seq", 32'(bus.o_seq_cnt), 32'd0);
    bus.i_pause = 1'b0;
    vb_rise(0);
    settle(100);
    chk("unpause_seq", 32'(bus.o_seq_cnt), 32'd1);
    chk("sb_empty_pause", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during WAIT(1); aborted sequence must not resume
    do_reset();
    resp_dly[1] = 0;
    vb_rise(0);
    wait_start(1, 100);
    repeat (3) cyc();
    chk("pre_rst_busy", 32'(bus.o_busy), 32'd1);
    #3 rst = 1'b1;
    #1 chk("async_rst_outs", 32'(outs()), 32'd0);
    model_clear();
    repeat (2) cyc();
    rst = 1'b0;
    repeat (8) cyc();
    chk("post_rst_no_tick", 32'(frames), 32'd0);
    chk("post_rst_idle", 32'(outs()), 32'd0);
    vb_rise(0);
    settle(100);
    chk("restart_latency", 32'(start_cyc[0] - rise_cyc), 32'd4);
    chk("restart_seq", 32'(bus.o_seq_cnt), 32'd1);
    chk("sb_empty_rst", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame game-update scheduler for the Pong display path. It detects the start of vertical blank and triggers the four game-logic update units in a fixed order: paddle, ball, collision, score. Each unit gets a start/done handshake, and the sequence finishes inside blanking so `img_generator` never reads half-updated state. It runs on the 25 MHz pixel clock and sits between `vsync` and the game-logic units.

## Interface
Parameters:
- `TIMEOUT`, default 800: maximum number of cycles to wait for one unit's done (one scan line).
- `TW`, default 10: width of the timeout counter. It must satisfy 2^TW > TIMEOUT.

Ports:
- `i_clk`, in, 1: pixel clock (`CLOCK_25`).
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_vblank`, in, 1: vertical-blank level from `vsync`. It is not synchronous to `i_clk`.
- `i_pause`, in, 1: level. While high, the block runs no update sequences.
- `i_speed`, in, 2: update every `i_speed+1` frames. Sampled only at a frame tick.
- `i_done`, in, 4: done pulses from the units. Bit 0 is paddle, 1 is ball, 2 is collision, 3 is score.
- `o_start`, out, 4: one-hot, single-cycle start pulse to each unit, same bit order as `i_done`.
- `o_busy`, out, 1: high whenever the state is not IDLE.
- `o_frame`, out, 1: single-cycle pulse for every detected frame tick.
- `o_overrun`, out, 1: sticky. Set when a frame tick arrives while busy.
- `o_timeout`, out, 1: sticky. Set when any unit fails to answer within `TIMEOUT` cycles.
- `o_seq_cnt`, out, 8: count of completed sequences. Wraps from 255 to 0.

## Operation
Synchronizer and frame tick:
- `i_vblank` passes through a 2-flop synchronizer, then a third flop for edge detection.
- All three flops reset to 1, so a vblank that is already high at reset release produces no tick.
- A frame tick is the synchronized rising edge of `i_vblank`.

Frame divider (`div_cnt`, 2 bits):
- On each accepted tick (state IDLE, `i_pause` low):
  - If `div_cnt == i_speed`, the update is due and `div_cnt` is cleared to 0.
  - Otherwise `div_cnt` increments and no sequence runs.
- While `i_pause` is high, `div_cnt` is held at 0 and ticks start nothing. `o_frame` still pulses.

States: IDLE, ISSUE(k), WAIT(k), DONE, with k = 0..3 held in a 2-bit step register.
- IDLE → ISSUE(0) on a due tick.
- ISSUE(k): `o_start[k]` = 1 for exactly this one cycle. The timeout counter clears. Next state is WAIT(k).
- WAIT(k): only `i_done[k]` is examined. Other `i_done` bits, and any done seen during ISSUE, are ignored.
  - On `i_done[k]`: go to ISSUE(k+1), or to DONE if k = 3.
  - If the counter reaches `TIMEOUT-1` without `i_done[k]`: set `o_timeout` and advance exactly as if done had arrived.
  - If `i_done[k]` arrives in that same cycle, it counts as done and `o_timeout` is not set.
- DONE: `o_seq_cnt` increments. Next state is IDLE.

Overrun:
- A tick while the state is not IDLE sets `o_overrun` and is dropped.
- A dropped tick does not advance `div_cnt` and does not disturb the current sequence. `o_frame` still pulses.

Reset:
- Asserting `i_rst` at any time, including mid-sequence, forces state IDLE, step 0, `div_cnt` 0 and counters 0.
- All outputs reset to 0: `o_start`, `o_busy`, `o_frame`, `o_overrun`, `o_timeout`, `o_seq_cnt`.
- An aborted sequence is not resumed.

Sticky flags clear only on reset.

## Timing
- All outputs are registered or decoded directly from registered state. There is no combinational path from any input to any output.
- Tick latency: take E0 as the first `i_clk` edge that samples `i_vblank` high. `o_frame` is high in the cycle after edge E3.
- When the tick is due, `o_start[0]` is high in that same cycle and `o_busy` rises with it.
- Per step: a unit that pulses done in the cycle after its start costs 2 cycles (ISSUE + WAIT).
  - Minimum sequence: 4×2 + 1 (DONE) = 9 cycles from `o_start[0]` to `o_busy` low.
  - `o_seq_cnt` updates at the edge that ends DONE.
- Worst case: 4×(TIMEOUT+1)+1 cycles. This must fit inside the vertical blank (45 lines × 800 cycles).

## Test plan
- Reset release with `i_vblank` held high, then `i_vblank` toggled low→high, units responding after 1 cycle, `i_speed`=0 → exactly one `o_frame`. `o_start` pulses in order 1,2,4,8, spaced 2 cycles apart. `o_busy` is high for 9 cycles. `o_seq_cnt`=1.
- `i_speed`=2, six vblank rises → sequences run on ticks 1 and 4 only. Six `o_frame` pulses. `o_seq_cnt`=2.
- Ball unit never answers, `TIMEOUT`=800 → `o_start[2]` asserts 801 cycles after `o_start[1]`. `o_timeout`=1. Sequence completes with `o_seq_cnt`=1.
- Collision unit delayed 5000 cycles while a second vblank edge arrives → `o_overrun`=1. The current sequence continues. `div_cnt` is unchanged.
- `i_pause`=1 across three vblank rises → three `o_frame` pulses, `o_start` stays 0, `o_seq_cnt` unchanged. After release, the next rise starts a sequence.
- `i_rst` pulsed during WAIT(1) → all outputs 0 asynchronously. With `i_vblank` high at release there is no tick. The next rising edge restarts the sequence at `o_start[0]`.
